sp_ram_dma_port: RTL and testbench

//  Request front-end placed directly upstream of the data-RAM wrapper. Muxes the core LSU port with a

---
 rtl/sp_ram_dma_pkg.sv | 18 +
 rtl/sp_ram_dma_fifo.sv | 55 +++++
 rtl/sp_ram_dma_port.sv | 178 +++++++++++++++++
 tb/tb_sp_ram_dma_port.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_dma_pkg.sv
// Shared types and constants for the RAM front-end and its block-copy engine.
package sp_ram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

    typedef enum logic {
        DMA_WR = 1'b0,
        DMA_RD = 1'b1
    } dma_dir_e;

    localparam int unsigned LEN_MAX = 256;

endpackage

// File: rtl/sp_ram_dma_fifo.sv
// Two-entry register FIFO for engine read data; the head is always a flop, never the input.
module sp_ram_dma_fifo #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_push  = push_i & (cnt_q != 2'd2);
        do_pop   = pop_i & (cnt_q != 2'd0);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/sp_ram_dma_port.sv
// RAM request front-end: core LSU has strict priority, the block-copy engine fills idle cycles.
module sp_ram_dma_port
    import sp_ram_dma_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 9
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    core_req_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic                    core_we_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    input  logic                    cfg_start_i,
    input  logic                    cfg_dir_i,
    input  logic [ADDR_WIDTH-1:0]   cfg_base_i,
    input  logic [LEN_WIDTH-1:0]    cfg_len_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    s_valid_i,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    output logic                    s_ready_o,
    output logic                    m_valid_o,
    output logic [DATA_WIDTH-1:0]   m_data_o,
    input  logic                    m_ready_i,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    dma_state_e            state_q, state_d;
    dma_dir_e              dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  zero_done_q, zero_done_d;
    logic                  core_rvalid_q, core_rvalid_d;
    logic                  rd_inflight_q, rd_inflight_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]            fifo_count;
    logic [2:0]            fifo_free;
    logic                  run_slot, eng_issue;
    logic [LEN_WIDTH-1:0]  len_eff;

    // Read data returns one cycle after issue; the owner flags decide who receives it.
    assign fifo_push = rd_inflight_q & ~fifo_full;
    assign fifo_pop  = m_ready_i & ~fifo_empty;

    sp_ram_dma_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst_i  (rst_i),
        .push_i (fifo_push),
        .data_i (ram_rdata_i),
        .pop_i  (fifo_pop),
        .data_o (m_data_o),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    always_comb begin
        // A pop this cycle frees a slot in time for data returning next cycle.
        fifo_free = 3'd2 - {1'b0, fifo_count} + {2'b00, fifo_pop};
        run_slot  = (state_q == RUN) & ~core_req_i;
        if (dir_q == DMA_WR) begin
            eng_issue = run_slot & s_valid_i;
        end else begin
            eng_issue = run_slot & (fifo_free > {2'b00, rd_inflight_q});
        end
        s_ready_o = run_slot & (dir_q == DMA_WR);
    end

    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        if (core_req_i) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = core_addr_i;
            ram_wdata_o = core_wdata_i;
            ram_we_o    = core_we_i;
            ram_be_o    = core_be_i;
        end else if (eng_issue) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = addr_q;
            ram_wdata_o = (dir_q == DMA_WR) ? s_data_i : '0;
            ram_we_o    = (dir_q == DMA_WR);
            ram_be_o    = '1;
        end
    end

    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        zero_done_d   = 1'b0;
        core_rvalid_d = core_req_i;
        rd_inflight_d = eng_issue & (dir_q == DMA_RD);
        len_eff       = (cfg_len_i > LEN_WIDTH'(LEN_MAX)) ? LEN_WIDTH'(LEN_MAX) : cfg_len_i;

        unique case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    if (len_eff != '0) begin
                        state_d = RUN;
                        dir_d   = dma_dir_e'(cfg_dir_i);
                        addr_d  = cfg_base_i & ~ADDR_WIDTH'(3);
                        rem_d   = len_eff;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (eng_issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(4);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = (dir_q == DMA_WR) ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!rd_inflight_q && fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            dir_q         <= DMA_WR;
            addr_q        <= '0;
            rem_q         <= '0;
            zero_done_q   <= 1'b0;
            core_rvalid_q <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            zero_done_q   <= zero_done_d;
            core_rvalid_q <= core_rvalid_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    assign core_gnt_o    = core_req_i;
    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rvalid_q ? ram_rdata_i : '0;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE) | zero_done_q;
    assign m_valid_o     = ~fifo_empty;

endmodule

// File: tb/tb_sp_ram_dma_port.sv
// Self-checking bench for sp_ram_dma_port with a behavioural single-port RAM and scoreboards.
module tb_sp_ram_dma_port;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          core_req_i, core_we_i;
    logic [AW-1:0] core_addr_i;
    logic [3:0]    core_be_i;
    logic [DW-1:0] core_wdata_i;
    logic          core_gnt_o, core_rvalid_o;
    logic [DW-1:0] core_rdata_o;
    logic          cfg_start_i, cfg_dir_i;
    logic [AW-1:0] cfg_base_i;
    logic [LW-1:0] cfg_len_i;
    logic          busy_o, done_o;
    logic          s_valid_i, s_ready_o;
    logic [DW-1:0] s_data_i;
    logic          m_valid_o, m_ready_i;
    logic [DW-1:0] m_data_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [3:0]    ram_be_o;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [0:8191];

    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [DW-1:0] stream_q  [$];
    logic [DW-1:0] core_q    [$];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [DW-1:0] CORE_WORD = 32'hC0DE_0040;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end
            ram_rdata <= mem[ram_addr_o[AW-1:2]];
        end
    end

    sp_ram_dma_port dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_addr_i  (core_addr_i),
        .core_we_i    (core_we_i),
        .core_be_i    (core_be_i),
        .core_wdata_i (core_wdata_i),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .cfg_start_i  (cfg_start_i),
        .cfg_dir_i    (cfg_dir_i),
        .cfg_base_i   (cfg_base_i),
        .cfg_len_i    (cfg_len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .ram_en_o     (ram_en_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_we_o     (ram_we_o),
        .ram_be_o     (ram_be_o),
        .ram_rdata_i  (ram_rdata)
    );

    task automatic idle_inputs();
        core_req_i   = 1'b0;
        core_we_i    = 1'b0;
        core_addr_i  = '0;
        core_be_i    = '0;
        core_wdata_i = '0;
        cfg_start_i  = 1'b0;
        cfg_dir_i    = 1'b0;
        cfg_base_i   = '0;
        cfg_len_i    = '0;
        s_valid_i    = 1'b0;
        s_data_i     = '0;
        m_ready_i    = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        n_tests++;
        if (ram_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || m_valid_o !== 1'b0 ||
            core_rvalid_o !== 1'b0 || s_ready_o !== 1'b0 || m_data_o !== '0 ||
            core_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL %s: en=%b busy=%b done=%b mv=%b rv=%b sr=%b md=%h, required all 0",
                     name, ram_en_o, busy_o, done_o, m_valid_o, core_rvalid_o, s_ready_o, m_data_o);
        end
    endtask

    task automatic start(input logic dir, input logic [AW-1:0] base, input int len);
        @(negedge clk);
        cfg_start_i = 1'b1;
        cfg_dir_i   = dir;
        cfg_base_i  = base;
        cfg_len_i   = LW'(len);
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        core_req_i   = 1'b1;
        core_we_i    = 1'b1;
        core_be_i    = 4'hF;
        core_addr_i  = a;
        core_wdata_i = d;
        #1;
        n_tests++;
        if (core_gnt_o !== 1'b1 || ram_en_o !== 1'b1 || ram_we_o !== 1'b1 ||
            ram_addr_o !== a || ram_wdata_o !== d || ram_be_o !== 4'hF) begin
            n_fail++;
            $display("FAIL core_write_mux: gnt=%b en=%b we=%b addr=%h wd=%h, required 1 1 1 %h %h",
                     core_gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, a, d);
        end
        @(negedge clk);
        core_req_i = 1'b0;
        core_we_i  = 1'b0;
        #1;
        n_tests++;
        if (core_rvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL core_write_rvalid: got %b required 1", core_rvalid_o);
        end
    endtask

    task automatic run_wr(input logic [AW-1:0] base, input int len, input bit core_rd);
        int  sent = 0;
        int  first_cyc = -1;
        int  last_cyc = -1;
        bit  got_done = 1'b0;
        for (int i = 0; i < len; i++) begin
            wr_addr_q.push_back(base + AW'(4 * i));
            wr_data_q.push_back(32'hA000_0000 + (32'(base) << 8) + 32'(i));
        end
        start(1'b0, base, len);
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            cfg_start_i = 1'b0;
            core_req_i  = core_rd && (cyc % 2 == 0) && (sent < len);
            core_we_i   = 1'b0;
            core_addr_i = AW'(32'h40);
            s_valid_i   = (sent < len);
            s_data_i    = 32'hA000_0000 + (32'(base) << 8) + 32'(sent);
            #1;
            n_tests++;
            if (core_rvalid_o !== (core_q.size() != 0)) begin
                n_fail++;
                $display("FAIL core_rvalid cyc %0d: got %b required %b", cyc, core_rvalid_o,
                         core_q.size() != 0);
            end else if (core_rvalid_o) begin
                logic [DW-1:0] exp_c = core_q.pop_front();
                n_tests++;
                if (core_rdata_o !== exp_c) begin
                    n_fail++;
                    $display("FAIL core_rdata: got %h required %h", core_rdata_o, exp_c);
                end
            end
            if (core_req_i) begin
                n_tests++;
                if (core_gnt_o !== 1'b1 || ram_en_o !== 1'b1 || ram_we_o !== 1'b0 ||
                    ram_addr_o !== AW'(32'h40) || s_ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL core_priority: gnt=%b en=%b we=%b addr=%h sr=%b, required 1 1 0 040 0",
                             core_gnt_o, ram_en_o, ram_we_o, ram_addr_o, s_ready_o);
                end
                core_q.push_back(CORE_WORD);
            end else if (sent < len) begin
                n_tests++;
                if (s_ready_o !== 1'b1 || ram_en_o !== 1'b1 || ram_we_o !== 1'b1 ||
                    ram_be_o !== 4'hF || wr_addr_q.size() == 0 ||
                    ram_addr_o !== wr_addr_q[0] || ram_wdata_o !== wr_data_q[0]) begin
                    n_fail++;
                    $display("FAIL eng_write word %0d: sr=%b en=%b we=%b addr=%h wd=%h, required addr %h data %h",
                             sent, s_ready_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
                             base + AW'(4 * sent), s_data_i);
                end
                if (wr_addr_q.size() != 0) begin
                    void'(wr_addr_q.pop_front());
                    void'(wr_data_q.pop_front());
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                sent++;
            end
            if (done_o) begin
                got_done = 1'b1;
                n_tests++;
                if (sent != len || cyc != last_cyc + 1) begin
                    n_fail++;
                    $display("FAIL wr_done_timing: at cyc %0d after %0d words, required cyc %0d after %0d",
                             cyc, sent, last_cyc + 1, len);
                end
            end
        end
        s_valid_i  = 1'b0;
        core_req_i = 1'b0;
        n_tests++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL wr_timeout: done_o seen 0 required 1 (%0d of %0d words)", sent, len);
        end
        if (!core_rd) begin
            n_tests++;
            if (last_cyc - first_cyc != len - 1) begin
                n_fail++;
                $display("FAIL wr_throughput: span %0d cycles required %0d", last_cyc - first_cyc,
                         len - 1);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_after_done: done=%b busy=%b required 0 0", done_o, busy_o);
        end
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a = base + AW'(4 * i);
            logic [DW-1:0] d = 32'hA000_0000 + (32'(base) << 8) + 32'(i);
            n_tests++;
            if (mem[a[AW-1:2]] !== d) begin
                n_fail++;
                $display("FAIL ram_content @%h: got %h required %h", a, mem[a[AW-1:2]], d);
            end
        end
    endtask

    task automatic run_rd(input logic [AW-1:0] base, input int len, input int stall);
        int  issued = 0;
        bit  popped = 1'b0;
        bit  got_done = 1'b0;
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d = 32'hB000_0000 + (32'(base) << 8) + 32'(i);
            core_write(base + AW'(4 * i), d);
            stream_q.push_back(d);
        end
        start(1'b1, base, len);
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            cfg_start_i = 1'b0;
            m_ready_i   = (cyc >= stall);
            #1;
            if (m_valid_o && m_ready_i) begin
                logic [DW-1:0] exp_d = (stream_q.size() != 0) ? stream_q.pop_front() : 'x;
                popped = 1'b1;
                n_tests++;
                if (m_data_o !== exp_d) begin
                    n_fail++;
                    $display("FAIL stream_data: got %h required %h", m_data_o, exp_d);
                end
            end
            if (ram_en_o) begin
                n_tests++;
                if (ram_we_o !== 1'b0 || ram_addr_o !== base + AW'(4 * issued) ||
                    (!popped && issued >= 2)) begin
                    n_fail++;
                    $display("FAIL eng_read %0d: we=%b addr=%h popped=%b, required 0 %h and <=2 before pop",
                             issued, ram_we_o, ram_addr_o, popped, base + AW'(4 * issued));
                end
                issued++;
            end
            if (done_o) got_done = 1'b1;
        end
        m_ready_i = 1'b0;
        n_tests++;
        if (!got_done || issued != len || stream_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_complete: done=%b issued=%0d left=%0d, required 1 %0d 0", got_done,
                     issued, stream_q.size(), len);
            stream_q.delete();
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || m_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_after_done: busy=%b done=%b mv=%b required 0 0 0", busy_o, done_o,
                     m_valid_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset_held");
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        check_quiet("reset_released");
    endtask

    task automatic test_wr_basic();
        run_wr(AW'(32'h100), 4, 1'b0);
    endtask

    task automatic test_rd_backpressure();
        core_write(AW'(32'h40), CORE_WORD);
        run_rd(AW'(32'h200), 3, 5);
    endtask

    task automatic test_core_contention();
        run_wr(AW'(32'h300), 8, 1'b1);
    endtask

    task automatic test_wrap();
        run_wr(AW'(32'h7FFC), 2, 1'b0);
    endtask

    task automatic test_zero_len();
        start(1'b0, AW'(32'h500), 0);
        #1;
        n_tests++;
        if (ram_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_start: en=%b busy=%b done=%b required 0 0 0", ram_en_o, busy_o,
                     done_o);
        end
        @(negedge clk);
        cfg_start_i = 1'b0;
        #1;
        n_tests++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || ram_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: done=%b busy=%b en=%b required 1 0 0", done_o, busy_o,
                     ram_en_o);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || ram_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_after: done=%b busy=%b en=%b required 0 0 0", done_o, busy_o,
                     ram_en_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        start(1'b1, AW'(32'h200), 3);
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            cfg_start_i = 1'b0;
            #1;
            seen = ram_en_o;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid_issue: engine read seen 0 required 1");
        end
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_quiet("reset_mid_async");
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        check_quiet("reset_mid_discard");
        run_rd(AW'(32'h200), 3, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wr_basic();
        test_rd_backpressure();
        test_core_contention();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
